// File: rtl/warp_issue_pkg.sv
// Shared widths, the issued-instruction record and the helper that pulls one
// warp's fields out of the packed instruction-buffer head vectors.
package warp_issue_pkg;

   localparam int NUM_WARPS = 8;
   localparam int WID_BITS  = $clog2(NUM_WARPS);
   localparam int NUM_LANES = 16;
   localparam int ARCH_LEN  = 32;
   localparam int OP_BITS   = 9;
   localparam int REG_BITS  = 8;
   localparam int NUM_REGS  = 2 ** REG_BITS;

   typedef struct packed {
      logic [WID_BITS-1:0]  wid;
      logic [ARCH_LEN-1:0]  pc;
      logic [OP_BITS-1:0]   op;
      logic [REG_BITS-1:0]  rd;
      logic [REG_BITS-1:0]  rs1;
      logic [REG_BITS-1:0]  rs2;
      logic [REG_BITS-1:0]  rs3;
      logic [NUM_LANES-1:0] tmask;
   } issue_t;

   function automatic issue_t unpack_ibuf(
      input logic [WID_BITS-1:0]            wid,
      input logic [NUM_WARPS*ARCH_LEN-1:0]  pc_v,
      input logic [NUM_WARPS*OP_BITS-1:0]   op_v,
      input logic [NUM_WARPS*REG_BITS-1:0]  rd_v,
      input logic [NUM_WARPS*REG_BITS-1:0]  rs1_v,
      input logic [NUM_WARPS*REG_BITS-1:0]  rs2_v,
      input logic [NUM_WARPS*REG_BITS-1:0]  rs3_v,
      input logic [NUM_WARPS*NUM_LANES-1:0] tm_v
   );
      issue_t t;
      t.wid   = wid;
      t.pc    = pc_v[ARCH_LEN*int'(wid) +: ARCH_LEN];
      t.op    = op_v[OP_BITS*int'(wid) +: OP_BITS];
      t.rd    = rd_v[REG_BITS*int'(wid) +: REG_BITS];
      t.rs1   = rs1_v[REG_BITS*int'(wid) +: REG_BITS];
      t.rs2   = rs2_v[REG_BITS*int'(wid) +: REG_BITS];
      t.rs3   = rs3_v[REG_BITS*int'(wid) +: REG_BITS];
      t.tmask = tm_v[NUM_LANES*int'(wid) +: NUM_LANES];
      return t;
   endfunction

endpackage

// File: rtl/warp_issue_arbiter_if.sv
// Frontend instruction-buffer heads, issue port and writeback port of the
// warp issue arbiter; slave is the arbiter side, master the surrounding pipe.
interface warp_issue_arbiter_if;
   import warp_issue_pkg::*;

   logic [NUM_WARPS-1:0]           ibuf_valid;
   logic [NUM_WARPS-1:0]           ibuf_ready;
   logic [NUM_WARPS*ARCH_LEN-1:0]  ibuf_pc;
   logic [NUM_WARPS*OP_BITS-1:0]   ibuf_op;
   logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rd;
   logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rs1;
   logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rs2;
   logic [NUM_WARPS*REG_BITS-1:0]  ibuf_rs3;
   logic [NUM_WARPS*NUM_LANES-1:0] ibuf_tmask;

   logic                 issue_valid;
   logic                 issue_ready;
   logic [WID_BITS-1:0]  issue_wid;
   logic [ARCH_LEN-1:0]  issue_pc;
   logic [OP_BITS-1:0]   issue_op;
   logic [REG_BITS-1:0]  issue_rd;
   logic [REG_BITS-1:0]  issue_rs1;
   logic [REG_BITS-1:0]  issue_rs2;
   logic [REG_BITS-1:0]  issue_rs3;
   logic [NUM_LANES-1:0] issue_tmask;

   logic                 wb_valid;
   logic [WID_BITS-1:0]  wb_wid;
   logic [REG_BITS-1:0]  wb_rd;

   logic                 sb_empty;

   modport slave (
      input  ibuf_valid, ibuf_pc, ibuf_op, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3, ibuf_tmask,
      output ibuf_ready,
      output issue_valid, issue_wid, issue_pc, issue_op, issue_rd, issue_rs1, issue_rs2,
             issue_rs3, issue_tmask,
      input  issue_ready,
      input  wb_valid, wb_wid, wb_rd,
      output sb_empty
   );

   modport master (
      output ibuf_valid, ibuf_pc, ibuf_op, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3, ibuf_tmask,
      input  ibuf_ready,
      input  issue_valid, issue_wid, issue_pc, issue_op, issue_rd, issue_rs1, issue_rs2,
             issue_rs3, issue_tmask,
      output issue_ready,
      output wb_valid, wb_wid, wb_rd,
      input  sb_empty
   );

endinterface

// File: rtl/warp_issue_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// modulo N. Gives both a one-hot grant and its encoded index.
module rr_arbiter #(
   parameter  int N  = 8,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   always_comb begin
      logic [IW:0] w_pos;
      logic        w_found;
      gnt     = '0;
      gnt_idx = '0;
      w_found = 1'b0;
      w_pos   = '0;
      for (int i = 0; i < N; i++) begin
         w_pos = {1'b0, ptr} + (IW+1)'(i);
         if (w_pos >= (IW+1)'(N)) w_pos = w_pos - (IW+1)'(N);
         if (en && !w_found && req[w_pos[IW-1:0]]) begin
            w_found                = 1'b1;
            gnt[w_pos[IW-1:0]]     = 1'b1;
            gnt_idx                = w_pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/warp_issue_arbiter.sv
// Picks one hazard-free warp per cycle, tracks outstanding destination
// registers per warp, and holds the chosen instruction in the issue register.
module warp_issue_arbiter
   import warp_issue_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   warp_issue_arbiter_if.slave  bus
);

   logic [NUM_WARPS-1:0] w_eligible;
   logic [NUM_WARPS-1:0] w_gnt;
   logic [NUM_WARPS-1:0] w_any_pend;
   logic [WID_BITS-1:0]  w_gnt_idx;
   logic                 w_can_accept;
   logic                 w_fire;

   logic [WID_BITS-1:0]  r_rr_ptr;
   logic                 r_issue_valid;
   issue_t               r_issue;

   assign w_can_accept = ~r_issue_valid | bus.issue_ready;
   assign w_fire       = |w_gnt;

   // Per-warp scoreboard row; register 0 never gets a pending bit.
   for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
      logic [REG_BITS-1:0] w_rd, w_rs1, w_rs2, w_rs3;
      logic [NUM_REGS-1:0] w_set, w_clr;
      logic [NUM_REGS-1:0] r_pend;

      assign w_rd  = bus.ibuf_rd [REG_BITS*g +: REG_BITS];
      assign w_rs1 = bus.ibuf_rs1[REG_BITS*g +: REG_BITS];
      assign w_rs2 = bus.ibuf_rs2[REG_BITS*g +: REG_BITS];
      assign w_rs3 = bus.ibuf_rs3[REG_BITS*g +: REG_BITS];

      assign w_eligible[g] = bus.ibuf_valid[g] &
                             ~(r_pend[w_rs1] | r_pend[w_rs2] | r_pend[w_rs3] | r_pend[w_rd]);

      assign w_set = (w_gnt[g] && w_rd != '0) ? (NUM_REGS'(1) << w_rd) : '0;
      assign w_clr = (bus.wb_valid && bus.wb_wid == WID_BITS'(g) && bus.wb_rd != '0)
                     ? (NUM_REGS'(1) << bus.wb_rd) : '0;

      // Clear applied before set so a same-edge issue of that register wins.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) r_pend <= '0;
         else        r_pend <= (r_pend & ~w_clr) | w_set;
      end

      assign w_any_pend[g] = |r_pend;
   end

   rr_arbiter #(.N(NUM_WARPS)) u_rr (
      .req     (w_eligible),
      .ptr     (r_rr_ptr),
      .en      (w_can_accept),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_issue_valid <= 1'b0;
         r_issue       <= '0;
         r_rr_ptr      <= '0;
      end else if (w_fire) begin
         r_issue_valid <= 1'b1;
         r_issue       <= unpack_ibuf(w_gnt_idx, bus.ibuf_pc, bus.ibuf_op, bus.ibuf_rd,
                                      bus.ibuf_rs1, bus.ibuf_rs2, bus.ibuf_rs3, bus.ibuf_tmask);
         r_rr_ptr      <= (w_gnt_idx == WID_BITS'(NUM_WARPS-1)) ? '0 : w_gnt_idx + 1'b1;
      end else if (bus.issue_ready) begin
         r_issue_valid <= 1'b0;
      end
   end

   // Grants are masked while in reset so no dequeue is signalled upstream.
   assign bus.ibuf_ready  = w_gnt & {NUM_WARPS{reset}};
   assign bus.issue_valid = r_issue_valid;
   assign bus.issue_wid   = r_issue.wid;
   assign bus.issue_pc    = r_issue.pc;
   assign bus.issue_op    = r_issue.op;
   assign bus.issue_rd    = r_issue.rd;
   assign bus.issue_rs1   = r_issue.rs1;
   assign bus.issue_rs2   = r_issue.rs2;
   assign bus.issue_rs3   = r_issue.rs3;
   assign bus.issue_tmask = r_issue.tmask;
   assign bus.sb_empty    = ~|w_any_pend;

endmodule

// File: tb/tb_warp_issue_arbiter.sv
// Randomized and directed bench for warp_issue_arbiter against a behavioural
// model of instruction heads, pending-register sets and the round-robin rule.
module tb_warp_issue_arbiter;
   import warp_issue_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   warp_issue_arbiter_if bus();

   warp_issue_arbiter dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Instruction-buffer heads as the frontend would present them
   bit                   h_vld [NUM_WARPS];
   logic [ARCH_LEN-1:0]  h_pc  [NUM_WARPS];
   logic [OP_BITS-1:0]   h_op  [NUM_WARPS];
   logic [REG_BITS-1:0]  h_rd  [NUM_WARPS];
   logic [REG_BITS-1:0]  h_rs1 [NUM_WARPS];
   logic [REG_BITS-1:0]  h_rs2 [NUM_WARPS];
   logic [REG_BITS-1:0]  h_rs3 [NUM_WARPS];
   logic [NUM_LANES-1:0] h_tm  [NUM_WARPS];
   bit                   wb_v;
   logic [WID_BITS-1:0]  wb_w;
   logic [REG_BITS-1:0]  wb_r;
   bit                   iss_rdy;

   // Reference model state
   bit     m_pend [NUM_WARPS][NUM_REGS];
   int     m_rr;
   bit     m_iv;
   issue_t m_iss;
   int     wbq_w[$];
   int     wbq_r[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int w = 0; w < NUM_WARPS; w++)
         for (int r = 0; r < NUM_REGS; r++) m_pend[w][r] = 1'b0;
      m_rr = 0;
      m_iv = 1'b0;
      m_iss = '0;
      wbq_w.delete();
      wbq_r.delete();
   endtask

   function automatic int model_grant();
      int w;
      if (m_iv && !iss_rdy) return -1;
      for (int i = 0; i < NUM_WARPS; i++) begin
         w = (m_rr + i) % NUM_WARPS;
         if (h_vld[w] && !m_pend[w][h_rs1[w]] && !m_pend[w][h_rs2[w]] &&
             !m_pend[w][h_rs3[w]] && !m_pend[w][h_rd[w]]) return w;
      end
      return -1;
   endfunction

   function automatic bit model_empty();
      for (int w = 0; w < NUM_WARPS; w++)
         for (int r = 0; r < NUM_REGS; r++) if (m_pend[w][r]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive();
      for (int w = 0; w < NUM_WARPS; w++) begin
         bus.ibuf_valid[w]                         = h_vld[w];
         bus.ibuf_pc   [ARCH_LEN*w  +: ARCH_LEN]   = h_pc[w];
         bus.ibuf_op   [OP_BITS*w   +: OP_BITS]    = h_op[w];
         bus.ibuf_rd   [REG_BITS*w  +: REG_BITS]   = h_rd[w];
         bus.ibuf_rs1  [REG_BITS*w  +: REG_BITS]   = h_rs1[w];
         bus.ibuf_rs2  [REG_BITS*w  +: REG_BITS]   = h_rs2[w];
         bus.ibuf_rs3  [REG_BITS*w  +: REG_BITS]   = h_rs3[w];
         bus.ibuf_tmask[NUM_LANES*w +: NUM_LANES]  = h_tm[w];
      end
      bus.issue_ready = iss_rdy;
      bus.wb_valid    = wb_v;
      bus.wb_wid      = wb_w;
      bus.wb_rd       = wb_r;
   endtask

   task automatic set_head(input int w, input int rd, input int rs1, input int rs2, input int rs3);
      h_vld[w] = 1'b1;
      h_pc[w]  = ARCH_LEN'($urandom);
      h_op[w]  = OP_BITS'($urandom);
      h_tm[w]  = NUM_LANES'($urandom);
      h_rd[w]  = REG_BITS'(rd);
      h_rs1[w] = REG_BITS'(rs1);
      h_rs2[w] = REG_BITS'(rs2);
      h_rs3[w] = REG_BITS'(rs3);
   endtask

   task automatic clear_heads();
      for (int w = 0; w < NUM_WARPS; w++) h_vld[w] = 1'b0;
      wb_v = 1'b0;
   endtask

   // One clock: compare DUT against model mid-cycle, then advance the model.
   task automatic step();
      int g;
      drive();
      @(negedge clock);
      g = model_grant();
      chk("ibuf_ready",  64'(bus.ibuf_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
      chk("issue_valid", 64'(bus.issue_valid), 64'(m_iv));
      chk("issue_wid",   64'(bus.issue_wid),   64'(m_iss.wid));
      chk("issue_pc",    64'(bus.issue_pc),    64'(m_iss.pc));
      chk("issue_op",    64'(bus.issue_op),    64'(m_iss.op));
      chk("issue_rd",    64'(bus.issue_rd),    64'(m_iss.rd));
      chk("issue_rs1",   64'(bus.issue_rs1),   64'(m_iss.rs1));
      chk("issue_rs2",   64'(bus.issue_rs2),   64'(m_iss.rs2));
      chk("issue_rs3",   64'(bus.issue_rs3),   64'(m_iss.rs3));
      chk("issue_tmask", 64'(bus.issue_tmask), 64'(m_iss.tmask));
      chk("sb_empty",    64'(bus.sb_empty),    64'(model_empty()));
      @(posedge clock);
      if (wb_v && wb_r != 0) m_pend[wb_w][wb_r] = 1'b0;
      if (g >= 0) begin
         m_iss.wid   = WID_BITS'(g);
         m_iss.pc    = h_pc[g];
         m_iss.op    = h_op[g];
         m_iss.rd    = h_rd[g];
         m_iss.rs1   = h_rs1[g];
         m_iss.rs2   = h_rs2[g];
         m_iss.rs3   = h_rs3[g];
         m_iss.tmask = h_tm[g];
         m_iv = 1'b1;
         if (h_rd[g] != 0) begin
            m_pend[g][h_rd[g]] = 1'b1;
            wbq_w.push_back(g);
            wbq_r.push_back(int'(h_rd[g]));
         end
         m_rr = (g + 1) % NUM_WARPS;
         h_vld[g] = 1'b0;
      end else if (iss_rdy) begin
         m_iv = 1'b0;
      end
      #1;
   endtask

   task automatic wb_pop(input int idx);
      wb_v = 1'b1;
      wb_w = WID_BITS'(wbq_w[idx]);
      wb_r = REG_BITS'(wbq_r[idx]);
      wbq_w.delete(idx);
      wbq_r.delete(idx);
   endtask

   task automatic drain();
      while (wbq_w.size() > 0) begin
         wb_pop(0);
         step();
      end
      wb_v = 1'b0;
      step();
   endtask

   initial begin
      clear_heads();
      iss_rdy = 1'b1;
      wb_w = '0;
      wb_r = '0;
      model_reset();

      // In reset: heads valid but nothing granted, everything at reset value
      for (int w = 0; w < NUM_WARPS; w++) set_head(w, 0, 0, 0, 0);
      drive();
      #12;
      chk("rst_ibuf_ready",  64'(bus.ibuf_ready),  64'd0);
      chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
      chk("rst_issue_pc",    64'(bus.issue_pc),    64'd0);
      chk("rst_sb_empty",    64'(bus.sb_empty),    64'd1);
      @(posedge clock); #1;
      reset = 1'b1;
      clear_heads();

      // Dependent instruction waits for writeback, then issues next cycle
      set_head(0, 5, 1, 0, 0);
      step();
      chk("t1_valid", 64'(bus.issue_valid), 64'd1);
      chk("t1_wid",   64'(bus.issue_wid),   64'd0);
      chk("t1_rd",    64'(bus.issue_rd),    64'd5);
      set_head(0, 6, 5, 0, 0);
      drive(); #1;
      chk("t1_hold", 64'(bus.ibuf_ready), 64'd0);
      step();
      step();
      wb_pop(0);
      step();
      wb_v = 1'b0;
      drive(); #1;
      chk("t1_wb_ready", 64'(bus.ibuf_ready), 64'd1);
      step();
      chk("t1_dep_rs1", 64'(bus.issue_rs1), 64'd5);
      drain();

      // All warps independent: strict rotation starting after warp 0
      for (int w = 0; w < NUM_WARPS; w++) set_head(w, 0, 0, 0, 0);
      for (int k = 0; k < 9; k++) begin
         step();
         chk("rr_order", 64'(bus.issue_wid), 64'((1 + k) % NUM_WARPS));
         set_head((1 + k) % NUM_WARPS, 0, 0, 0, 0);
      end
      clear_heads();
      set_head(2, 0, 0, 0, 0);
      step();
      clear_heads();
      set_head(1, 0, 0, 0, 0);
      set_head(5, 0, 0, 0, 0);
      step();
      chk("rr_skip", 64'(bus.issue_wid), 64'd5);

      // Downstream stall holds everything
      for (int w = 0; w < NUM_WARPS; w++) set_head(w, 0, 0, 0, 0);
      iss_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("stall_ready", 64'(bus.ibuf_ready), 64'd0);
         chk("stall_wid",   64'(bus.issue_wid),  64'd5);
      end
      iss_rdy = 1'b1;
      step();
      chk("stall_resume", 64'(bus.issue_wid), 64'd6);
      clear_heads();
      step();

      // Same-edge issue and writeback of warp 2 r7: the set survives
      set_head(2, 7, 0, 0, 0);
      wb_v = 1'b1;
      wb_w = 3'd2;
      wb_r = 8'd7;
      step();
      wb_v = 1'b0;
      drive(); #1;
      chk("setwins_sb_empty", 64'(bus.sb_empty), 64'd0);
      drain();

      // rd=0 instructions stream every cycle without touching the scoreboard
      for (int k = 0; k < 5; k++) begin
         set_head(3, 0, 1, 2, 3);
         step();
         chk("b2b_wid",   64'(bus.issue_wid), 64'd3);
         chk("b2b_empty", 64'(bus.sb_empty),  64'd1);
      end
      clear_heads();
      step();

      // Randomized traffic with small register numbers to force hazards
      for (int c = 0; c < 400; c++) begin
         iss_rdy = ($urandom_range(0, 3) != 0);
         for (int w = 0; w < NUM_WARPS; w++)
            if (!h_vld[w] && $urandom_range(0, 1) == 1)
               set_head(w, $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom_range(0, 7));
         wb_v = 1'b0;
         if (wbq_w.size() > 0 && $urandom_range(0, 2) == 0) begin
            wb_pop($urandom_range(0, wbq_w.size() - 1));
         end else if ($urandom_range(0, 7) == 0) begin
            wb_v = 1'b1;
            wb_w = WID_BITS'($urandom);
            wb_r = ($urandom_range(0, 1) == 0) ? 8'd0 : REG_BITS'($urandom_range(8, 255));
         end
         step();
      end
      wb_v = 1'b0;
      iss_rdy = 1'b1;
      clear_heads();
      drain();

      // Reset mid-stream with a held issue and three pending registers
      set_head(1, 4, 0, 0, 0);
      set_head(2, 4, 0, 0, 0);
      set_head(3, 4, 0, 0, 0);
      step();
      step();
      step();
      for (int w = 0; w < NUM_WARPS; w++) set_head(w, 0, 0, 0, 0);
      iss_rdy = 1'b0;
      drive();
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_valid",    64'(bus.issue_valid), 64'd0);
      chk("mid_rst_wid",      64'(bus.issue_wid),   64'd0);
      chk("mid_rst_rd",       64'(bus.issue_rd),    64'd0);
      chk("mid_rst_sb_empty", 64'(bus.sb_empty),    64'd1);
      chk("mid_rst_ready",    64'(bus.ibuf_ready),  64'd0);
      model_reset();
      wb_v = 1'b1;
      wb_w = 3'd1;
      wb_r = 8'd4;
      drive();
      @(posedge clock); #1;
      reset = 1'b1;
      iss_rdy = 1'b1;
      step();
      chk("post_rst_first", 64'(bus.issue_wid), 64'd0);
      wb_v = 1'b0;
      step();
      chk("post_rst_second", 64'(bus.issue_wid), 64'd1);
      clear_heads();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/warp_issue_arbiter.md
# warp_issue_arbiter

Consumes the per-warp instruction-buffer heads from the Cyclotron frontend and selects at most one hazard-free warp per cycle for issue. Tracks outstanding destination registers per warp in a scoreboard cleared by writeback. Holds the selected instruction in a single pipelined output register toward the operand-collect/execute stage.

## Interface
- NUM_WARPS, 8, warp count; WID_BITS = $clog2(NUM_WARPS)
- NUM_LANES, 16, thread-mask width
- ARCH_LEN, 32, PC width
- OP_BITS, 9, opcode width (7-bit op plus 2-bit ext)
- REG_BITS, 8, register address width; NUM_REGS = 2**REG_BITS
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low (0 = in reset)
- ibuf_valid  in  NUM_WARPS  per-warp head valid
- ibuf_ready  out  NUM_WARPS  per-warp dequeue; one-hot or zero
- ibuf_pc  in  NUM_WARPS*ARCH_LEN  packed, warp w at [ARCH_LEN*w +: ARCH_LEN]
- ibuf_op  in  NUM_WARPS*OP_BITS  packed opcode
- ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3  in  NUM_WARPS*REG_BITS each  packed register addresses
- ibuf_tmask  in  NUM_WARPS*NUM_LANES  packed thread mask
- issue_valid  out  1  issue register occupied
- issue_ready  in  1  downstream accepts
- issue_wid  out  WID_BITS; issue_pc  out  ARCH_LEN; issue_op  out  OP_BITS
- issue_rd, issue_rs1, issue_rs2, issue_rs3  out  REG_BITS each
- issue_tmask  out  NUM_LANES
- wb_valid  in  1  writeback retiring a destination
- wb_wid  in  WID_BITS; wb_rd  in  REG_BITS  retired warp/register
- sb_empty  out  1  no pending bit set in any warp

## Operation
- Scoreboard: pending[w][r], NUM_WARPS x NUM_REGS flops. Register 0 is never set.
- Eligible[w] = ibuf_valid[w] AND none of pending[w][rs1], pending[w][rs2], pending[w][rs3], pending[w][rd] set (WAW included). The check reads registered state only; there is no writeback bypass.
- can_accept = !issue_valid OR issue_ready.
- Grant: round-robin over eligible warps. Pick the lowest index w >= rr_ptr, wrapping modulo NUM_WARPS. Grant is valid only when can_accept. ibuf_ready = one-hot grant.
- On grant fire:
  - Load the issue register with the warp's fields, issue_wid = w.
  - Set pending[w][rd] if rd != 0.
  - rr_ptr <= (w+1) mod NUM_WARPS.
- No grant: rr_ptr holds.
- Issue register:
  - issue_valid <= 1 on grant.
  - Else issue_valid <= 0 if issue_ready.
  - Else holds with fields stable.
- wb_valid: clear pending[wb_wid][wb_rd] next edge. wb_rd = 0 is ignored.
- Same-cycle set and clear of the same [w][r]: set wins.
- sb_empty = NOR of all pending bits (registered state).

## Timing
- Reset values (async assert, sync-to-clock deassert handled upstream):
  - issue_valid = 0; all issue_* fields = 0.
  - rr_ptr = 0; all pending = 0; sb_empty = 1.
  - ibuf_ready = 0 while in reset.
- ibuf_ready is combinational from ibuf_valid, ibuf_rs*/rd, the scoreboard, issue_valid, issue_ready and rr_ptr. There is no combinational path from the wb_* inputs.
- Latency: ibuf fire at edge N gives issue_valid at N+1. Back-to-back issue sustains 1/cycle while issue_ready = 1.
- Dependent same-warp instruction: the earliest grant is the cycle after the writeback edge. Writeback at edge N gives eligible in cycle N+1.
- Reset asserted mid-operation: the issue register and all pending bits drop immediately. In-flight writebacks after reset are ignored (clearing a clear bit).
- Downstream stall (issue_ready = 0, issue_valid = 1): no grant, ibuf_ready = 0, rr_ptr frozen.

## Structure
- Shared package warp_issue_pkg:
  - issue_t struct {wid, pc, op, rd, rs1, rs2, rs3, tmask}, parameterized widths as localparams.
  - Unpack helper for packed ibuf vectors.
- Sub-module rr_arbiter #(N): inputs req[N], ptr, en; outputs one-hot gnt and encoded gnt_idx. It is reused by the writeback arbiter.
- The scoreboard is inline: per-warp NUM_REGS-bit vectors with 4 read muxes per warp.

## Test plan
- Single warp 0, instr rd=5 rs1=1: issue_valid at next cycle with issue_wid=0 and rd=5. The next warp-0 instr with rs1=5 is held (ibuf_ready[0]=0) until wb_valid wid=0 rd=5. The grant comes exactly 1 cycle after the wb edge.
- All 8 warps valid, independent, issue_ready=1: grants in order 0,1,…,7,0. Then with rr_ptr=3 and only warps 1 and 5 valid, warp 5 wins.
- Stall: issue_ready=0 for 4 cycles with issue_valid=1. Issue fields stay stable, all ibuf_ready=0, rr_ptr unchanged. Release resumes at the next warp.
- Same cycle: grant warp 2 rd=7 and wb warp 2 rd=7. pending[2][7]=1 afterwards and sb_empty=0.
- rd=0 instructions issue back-to-back on one warp every cycle; sb_empty stays 1.
- Assert reset mid-stream with issue_valid=1 and 3 pending bits: outputs are 0 and sb_empty=1 asynchronously. After release, warp 0 is granted first.
